// File: rtl/clk_en_rate_ctrl_if.sv
// rtl/clk_en_rate_ctrl_if.sv - rate request / clock-enable signal bundle for clk_en_rate_ctrl
interface clk_en_rate_ctrl_if;
    logic       iRateReq;
    logic [1:0] iRateSel;
    logic       iHold;
    logic       oClkEn;
    logic       oRateAck;
    logic       oBusy;
    logic [1:0] oActiveSel;

    modport master (
        output iRateReq,
        output iRateSel,
        output iHold,
        input  oClkEn,
        input  oRateAck,
        input  oBusy,
        input  oActiveSel
    );

    modport slave (
        input  iRateReq,
        input  iRateSel,
        input  iHold,
        output oClkEn,
        output oRateAck,
        output oBusy,
        output oActiveSel
    );
endinterface

// File: rtl/clk_en_rate_ctrl.sv
// rtl/clk_en_rate_ctrl.sv - fractional clock-enable generator with glitch-free runtime rate switching
module clk_en_rate_ctrl #(
    parameter int unsigned CLK_IN = 10000000,
    parameter int unsigned RATE0  = 4772727,
    parameter int unsigned RATE1  = 7159090,
    parameter int unsigned RATE2  = 9545454,
    parameter int unsigned RATE3  = 0,
    parameter int unsigned ACC_W  = 26
) (
    input  logic                iClk,
    input  logic                iRst,
    clk_en_rate_ctrl_if.slave   bus
);

    localparam logic [ACC_W-1:0] CLK_V = ACC_W'(CLK_IN);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  accum_q, accum_d;
    logic              clk_en_q, clk_en_d;
    logic              rate_ack_q, rate_ack_d;
    logic              busy_q, busy_d;
    logic [1:0]        active_sel_q, active_sel_d;
    logic [1:0]        pending_q, pending_d;

    logic [ACC_W-1:0]  rate;
    logic [ACC_W-1:0]  step_acc;
    logic              step_en;

    always_comb begin
        rate = '0;
        case (active_sel_q)
            2'd0:    rate = ACC_W'(RATE0);
            2'd1:    rate = ACC_W'(RATE1);
            2'd2:    rate = ACC_W'(RATE2);
            default: rate = ACC_W'(RATE3);
        endcase
    end

    // Overflow-free form of the fractional step: accum never exceeds CLK_IN + rate.
    always_comb begin
        step_acc = accum_q + rate;
        step_en  = 1'b0;
        if (accum_q >= CLK_V) begin
            step_acc = accum_q - (CLK_V - rate);
            step_en  = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        accum_d      = accum_q;
        clk_en_d     = 1'b0;
        rate_ack_d   = 1'b0;
        busy_d       = busy_q;
        active_sel_d = active_sel_q;
        pending_d    = pending_q;

        case (state_q)
            ST_RUN: begin
                if (!bus.iHold) begin
                    accum_d  = step_acc;
                    clk_en_d = step_en;
                end
                if (bus.iRateReq) begin
                    pending_d = bus.iRateSel;
                    busy_d    = 1'b1;
                    // A stopped rate never produces an enable, so it cannot be drained.
                    if ((bus.iRateSel == active_sel_q) || (rate == '0)) begin
                        state_d = ST_APPLY;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!bus.iHold) begin
                    accum_d  = step_acc;
                    clk_en_d = step_en;
                    if (step_en) begin
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_APPLY: begin
                active_sel_d = pending_q;
                accum_d      = '0;
                rate_ack_d   = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q      <= ST_RUN;
            accum_q      <= '0;
            clk_en_q     <= 1'b0;
            rate_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            active_sel_q <= 2'd0;
            pending_q    <= 2'd0;
        end else begin
            state_q      <= state_d;
            accum_q      <= accum_d;
            clk_en_q     <= clk_en_d;
            rate_ack_q   <= rate_ack_d;
            busy_q       <= busy_d;
            active_sel_q <= active_sel_d;
            pending_q    <= pending_d;
        end
    end

    assign bus.oClkEn     = clk_en_q;
    assign bus.oRateAck   = rate_ack_q;
    assign bus.oBusy      = busy_q;
    assign bus.oActiveSel = active_sel_q;

endmodule

// File: tb/tb_clk_en_rate_ctrl.sv
// tb/tb_clk_en_rate_ctrl.sv - directed and random checks of clk_en_rate_ctrl against a cycle model
module tb_clk_en_rate_ctrl;

    localparam int CLK_IN = 10;
    localparam int RATES [4] = '{5, 10, 3, 0};

    logic clk;
    logic rst;
    clk_en_rate_ctrl_if bus ();

    clk_en_rate_ctrl #(
        .CLK_IN (CLK_IN),
        .RATE0  (5),
        .RATE1  (10),
        .RATE2  (3),
        .RATE3  (0),
        .ACC_W  (8)
    ) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: accumulator value, what the outputs will read, and where a switch stands.
    int acc;
    int m_en, m_ack, m_busy, m_active, m_pend;
    bit draining, applying;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int r;
        if (rst) begin
            acc = 0; m_en = 0; m_ack = 0; m_busy = 0; m_active = 0; m_pend = 0;
            draining = 0; applying = 0;
            return;
        end
        r     = RATES[m_active];
        m_ack = 0;
        if (applying) begin
            m_active = m_pend; acc = 0; m_en = 0; m_ack = 1; m_busy = 0; applying = 0;
            return;
        end
        m_en = 0;
        if (!bus.iHold) begin
            if (acc >= CLK_IN) begin
                acc  = acc - CLK_IN + r;
                m_en = 1;
            end else begin
                acc = acc + r;
            end
        end
        if (draining) begin
            if (m_en == 1) begin
                draining = 0; applying = 1;
            end
        end else if (bus.iRateReq) begin
            m_pend = bus.iRateSel;
            m_busy = 1;
            if (bus.iRateSel == m_active[1:0] || r == 0) applying = 1;
            else draining = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("clk_en",     bus.oClkEn,     m_en);
        chk("rate_ack",   bus.oRateAck,   m_ack);
        chk("busy",       bus.oBusy,      m_busy);
        chk("active_sel", bus.oActiveSel, m_active);
    endtask

    task automatic request(input logic [1:0] sel);
        bus.iRateReq = 1'b1;
        bus.iRateSel = sel;
        step();
        bus.iRateReq = 1'b0;
    endtask

    int en_cnt;

    initial begin
        rst = 1'b1;
        bus.iRateReq = 1'b0;
        bus.iRateSel = 2'd0;
        bus.iHold    = 1'b0;
        step();
        step();
        chk("rst_clk_en", bus.oClkEn, 0);
        chk("rst_ack",    bus.oRateAck, 0);
        chk("rst_busy",   bus.oBusy, 0);
        chk("rst_active", bus.oActiveSel, 0);
        rst = 1'b0;

        // Half-rate pacing from reset: enable first on the third edge.
        step(); chk("t1_en_c1", bus.oClkEn, 0);
        step(); chk("t1_en_c2", bus.oClkEn, 0);
        step(); chk("t1_en_c3", bus.oClkEn, 1);
        en_cnt = 1;
        for (int i = 0; i < 97; i++) begin
            step();
            if (bus.oClkEn) en_cnt++;
        end
        chk("t1_density", (en_cnt >= 48 && en_cnt <= 50), 1);

        // Switch 0 -> 1 from mid-period; drain to the next enable.
        step();
        request(2'd1);
        chk("t2_busy", bus.oBusy, 1);
        step(); chk("t2_drain_en", bus.oClkEn, 1);
        step(); chk("t2_ack", bus.oRateAck, 1);
        chk("t2_active", bus.oActiveSel, 1);
        step(); chk("t2_first_idle", bus.oClkEn, 0);
        for (int i = 0; i < 5; i++) begin
            step(); chk("t2_full_rate", bus.oClkEn, 1);
        end

        // Same-code request: immediate, accumulator restarts.
        request(2'd1);
        step(); chk("t3_ack", bus.oRateAck, 1);
        chk("t3_active", bus.oActiveSel, 1);
        step(); chk("t3_restart", bus.oClkEn, 0);

        // Stop the enable, then leave the stopped rate.
        request(2'd3);
        repeat (3) step();
        chk("t4_active3", bus.oActiveSel, 3);
        en_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus.oClkEn) en_cnt++;
        end
        chk("t4_stopped", en_cnt, 0);
        request(2'd0);
        step(); chk("t4_ack", bus.oRateAck, 1);
        chk("t4_active0", bus.oActiveSel, 0);
        repeat (4) step();

        // Hold mid-drain freezes everything; drain finishes after release.
        request(2'd0);
        step();
        step();
        request(2'd2);
        bus.iHold = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t5_hold_en", bus.oClkEn, 0);
            chk("t5_hold_ack", bus.oRateAck, 0);
        end
        bus.iHold = 1'b0;
        step(); chk("t5_release_en", bus.oClkEn, 1);
        step(); chk("t5_ack", bus.oRateAck, 1);
        chk("t5_active", bus.oActiveSel, 2);

        // Second request while busy is ignored.
        request(2'd1);
        request(2'd3);
        for (int i = 0; i < 20 && !bus.oRateAck; i++) step();
        chk("t6_ack_seen", bus.oRateAck, 1);
        chk("t6_first_only", bus.oActiveSel, 1);
        step();
        repeat (3) step();

        // Reset during a drain discards the pending switch.
        request(2'd0);
        chk("t6_busy", bus.oBusy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_active", bus.oActiveSel, 0);
        chk("t6_rst_busy", bus.oBusy, 0);
        for (int i = 0; i < 6; i++) begin
            step(); chk("t6_no_ack", bus.oRateAck, 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.iRateReq = ($urandom_range(0, 7) == 0);
            bus.iRateSel = 2'($urandom_range(0, 3));
            bus.iHold    = ($urandom_range(0, 9) == 0);
            rst          = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        bus.iRateReq = 1'b0;
        bus.iHold = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
